flop_pipe: RTL and testbench
============================

FLOP_PIPE -- requirements
Module: flop_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the payload width in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter DEPTH, default 3, giving the number of register stages (DEPTH >= 1).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port flush  input  1  synchronous discard of all in-flight entries.
REQ-006 The block SHALL have port in_valid  input  1  upstream has data on in_data.
REQ-007 The block SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 The block SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 The block SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-010 The block SHALL have port out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 The block SHALL have port out_data  output  WIDTH  payload of the last stage.
REQ-012 The block SHALL have port occupancy  output  $clog2(DEPTH+1)  number of valid stages (present only per REQ-030).

Function
REQ-013 The block SHALL hold stages 0..DEPTH-1, each with one valid bit and one WIDTH-bit data register; stage DEPTH-1 SHALL drive out_valid/out_data directly from flops.
REQ-014 A transfer SHALL occur at an interface on any cycle where valid and ready are both 1; accept = in_valid & in_ready, consume = out_valid & out_ready.
REQ-015 The last stage SHALL advance (drop its entry) on consume; stage i < DEPTH-1 SHALL move into stage i+1 when stage i is valid and stage i+1 is empty or advancing.
REQ-016 Bubbles SHALL collapse: an invalid stage SHALL accept the entry behind it in the same cycle even when out_ready = 0.
REQ-017 in_ready SHALL be 1 when stage 0 is empty or stage 0 is advancing; in_ready MAY depend combinationally on out_ready through the stage chain.
REQ-018 With the pipe empty and out_ready held 1, an entry accepted in cycle t SHALL appear with out_valid = 1 in cycle t+DEPTH; steady-state throughput SHALL be one entry per cycle.
REQ-019 When full (all DEPTH stages valid) and out_ready = 0, in_ready SHALL be 0 and all stage contents SHALL hold unchanged.
REQ-020 When full and out_ready = 1, the block SHALL accept and consume in the same cycle (in_ready = 1) with occupancy unchanged.
REQ-021 Order SHALL be preserved; no entry SHALL be duplicated or dropped except by flush or reset.
REQ-022 out_data SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-023 A data register SHALL load only when its stage takes a new entry; a stage that empties SHALL retain stale data.
REQ-024 flush = 1 SHALL clear every valid bit at the next edge, take priority over accept and consume, and drop any entry offered in that cycle; in_ready SHALL be 0 while flush = 1.
REQ-025 DEPTH = 1 SHALL reduce to a single registered stage with in_ready = ~out_valid | out_ready.

Reset
REQ-026 Assertion of reset_n = 0 SHALL asynchronously clear all valid bits and all data registers to 0, without waiting for clk.
REQ-027 During reset out_valid SHALL be 0, out_data SHALL be 0, in_ready SHALL be 0, and occupancy SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard all entries; the first accept after deassertion SHALL be the first entry seen at out_data.
REQ-029 Release of reset_n SHALL be taken synchronously to clk by the integrator; the block SHALL add no reset synchroniser.

Configuration
REQ-030 With FLOP_PIPE_OCCUPANCY_EN defined, the block SHALL provide occupancy as a registered counter: +1 on accept without consume, -1 on consume without accept, 0 on flush; occupancy SHALL always equal the count of valid stages.
REQ-031 Without FLOP_PIPE_OCCUPANCY_EN, the block SHALL omit the occupancy port and counter, and all other behaviour SHALL be identical.

Verification
REQ-032 The bench SHALL run streaming: WIDTH=8, DEPTH=3, out_ready=1, inputs 0x01..0x10 on consecutive cycles -> 0x01 at out_data 3 cycles after its accept, then one entry per cycle in order.
REQ-033 The bench SHALL run backpressure: out_ready=0, inputs 0xA1,0xA2,0xA3,0xA4 -> first three accepted, in_ready=0 on 0xA4, occupancy=3; then out_ready=1 -> outputs in order 0xA1..0xA4.
REQ-034 The bench SHALL run bubble collapse: a single entry 0x55 with out_ready=0 -> it reaches stage 2 after 3 cycles and in_ready stays 1 until 3 entries are held.
REQ-035 The bench SHALL run flush: 2 entries in flight plus flush=1 with in_valid=1, in_data=0x77 -> next cycle out_valid=0, occupancy=0, and 0x77 never appears.
REQ-036 The bench SHALL run async reset: pipe full with 0xC1..0xC3, reset_n pulled low between edges -> out_valid=0 and out_data=0 immediately; after release, input 0xD0 is the first output.
REQ-037 The bench SHALL run DEPTH=1 simultaneous: full stage with in_valid=1 and out_ready=1 -> accept and consume in the same cycle, with out_data updated next cycle.

Source files
------------

// File: rtl/flop_pipe.sv
// flop_pipe: valid/ready register pipeline of DEPTH stages with bubble collapse
// and synchronous flush. Every stage has a valid flag and a WIDTH-bit payload
// register. The last stage drives out_valid/out_data directly from flops.
// Optional feature: define FLOP_PIPE_OCCUPANCY_EN to add the registered
// occupancy counter and its port.
module flop_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef FLOP_PIPE_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];

    logic [DEPTH-1:0] w_adv;     // stage i hands its entry onward this cycle
    logic [DEPTH-1:0] w_load;    // stage i takes a new entry this cycle
    logic             w_accept;
    logic             w_consume;

    // Advance per stage in closed form: a valid stage moves if any stage
    // above it is empty, or if everything above is full and downstream
    // consumes. This equals the recursive "next empty or advancing" rule
    // without a combinational chain through the w_adv vector itself.
    always_comb begin
        logic full_above;
        w_adv      = '0;
        full_above = 1'b1;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_adv[DEPTH-1-k] = r_valid[DEPTH-1-k] & (out_ready | ~full_above);
            full_above       = full_above & r_valid[DEPTH-1-k];
        end
    end

    assign w_consume = r_valid[DEPTH-1] & out_ready;
    assign in_ready  = reset_n & ~flush & (~r_valid[0] | w_adv[0]);
    assign w_accept  = in_valid & in_ready;

    // Stage load enables: stage 0 loads on accept, stage k from stage k-1.
    always_comb begin
        w_load    = '0;
        w_load[0] = w_accept;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            w_load[k] = w_adv[k-1] & ~flush;
        end
    end

    // Valid flags: flush wins over every move; otherwise a stage is full if
    // it loads or keeps an entry that is not leaving.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_load | (r_valid & ~w_adv);
        end
    end

    // Payload registers load only on a new entry; emptied stages keep stale data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_data[0] <= in_data;
            end
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (w_load[k]) begin
                    r_data[k] <= r_data[k-1];
                end
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];

`ifdef FLOP_PIPE_OCCUPANCY_EN
    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    logic [OCC_W-1:0] r_occ;

    // Entry counter tracking the number of valid stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            case ({w_accept, w_consume})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign occupancy = r_occ;
`endif

endmodule

// File: tb/tb_flop_pipe.sv
// Directed bench for flop_pipe: a DEPTH=3 instance for streaming,
// backpressure, bubble collapse, flush and async reset, and a DEPTH=1
// instance for simultaneous accept/consume. Occupancy checks are compiled
// in only when FLOP_PIPE_OCCUPANCY_EN is defined.
module tb_flop_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid;
    logic [7:0] out_data;

    logic       flush_1, in_valid_1, out_ready_1;
    logic [7:0] in_data_1;
    logic       in_ready_1, out_valid_1;
    logic [7:0] out_data_1;

`ifdef FLOP_PIPE_OCCUPANCY_EN
    logic [1:0] occupancy;
    logic       occupancy_1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] bp_in [4];

    always #5 clk = ~clk;

    flop_pipe #(.WIDTH(8), .DEPTH(3)) u_pipe3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FLOP_PIPE_OCCUPANCY_EN
        ,
        .occupancy (occupancy)
`endif
    );

    flop_pipe #(.WIDTH(8), .DEPTH(1)) u_pipe1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush_1),
        .in_valid  (in_valid_1),
        .in_ready  (in_ready_1),
        .in_data   (in_data_1),
        .out_valid (out_valid_1),
        .out_ready (out_ready_1),
        .out_data  (out_data_1)
`ifdef FLOP_PIPE_OCCUPANCY_EN
        ,
        .occupancy (occupancy_1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bp_in[0] = 8'hA1; bp_in[1] = 8'hA2; bp_in[2] = 8'hA3; bp_in[3] = 8'hA4;
        reset_n = 1'b0;
        flush = 1'b0; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
        flush_1 = 1'b0; in_valid_1 = 1'b1; in_data_1 = 8'h5A; out_ready_1 = 1'b1;

        // ---- reset state (inputs active, must be ignored) ----
        tick; tick;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_in_ready_d1", 32'(in_ready_1), 32'd0);
        check("rst_out_valid_d1", 32'(out_valid_1), 32'd0);
`ifdef FLOP_PIPE_OCCUPANCY_EN
        check("rst_occupancy", 32'(occupancy), 32'd0);
`endif
        in_valid = 1'b0; in_valid_1 = 1'b0;
        tick;
        reset_n = 1'b1;

        // ---- streaming 0x01..0x10, out_ready=1 ----
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 16);
            in_data  = 8'(c + 1);
            #1;
            if (c < 16) check("stream_in_ready", 32'(in_ready), 32'd1);
            check("stream_out_valid", 32'(out_valid), (c >= 3 && c < 19) ? 32'd1 : 32'd0);
            if (c >= 3 && c < 19) check("stream_out_data", 32'(out_data), 32'(c - 2));
            tick;
        end
        in_valid = 1'b0;

        // ---- backpressure ----
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_data = bp_in[c];
            #1;
            check("bp_in_ready_fill", 32'(in_ready), 32'd1);
            check("bp_out_valid_fill", 32'(out_valid), 32'd0);
            tick;
        end
        for (int c = 3; c < 5; c++) begin
            in_data = bp_in[3];
            #1;
            check("bp_in_ready_full", 32'(in_ready), 32'd0);
            check("bp_out_valid_full", 32'(out_valid), 32'd1);
            check("bp_out_data_hold", 32'(out_data), 32'hA1);
`ifdef FLOP_PIPE_OCCUPANCY_EN
            check("bp_occupancy_full", 32'(occupancy), 32'd3);
`endif
            tick;
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", 32'(in_ready), 32'd1);
        check("bp_out_data_first", 32'(out_data), 32'hA1);
        tick;
        in_valid = 1'b0;
        for (int c = 6; c < 9; c++) begin
            #1;
            check("bp_out_valid_drain", 32'(out_valid), 32'd1);
            check("bp_out_data_drain", 32'(out_data), 32'(bp_in[c-5]));
`ifdef FLOP_PIPE_OCCUPANCY_EN
            check("bp_occupancy_drain", 32'(occupancy), 32'(9 - c));
`endif
            tick;
        end
        #1;
        check("bp_out_valid_empty", 32'(out_valid), 32'd0);

        // ---- bubble collapse ----
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h55;
        #1;
        check("bub_in_ready_0", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        for (int c = 1; c < 3; c++) begin
            #1;
            check("bub_in_ready_idle", 32'(in_ready), 32'd1);
            check("bub_out_valid_travel", 32'(out_valid), 32'd0);
            tick;
        end
        in_valid = 1'b1; in_data = 8'h66;
        #1;
        check("bub_out_valid_arrive", 32'(out_valid), 32'd1);
        check("bub_out_data_arrive", 32'(out_data), 32'h55);
        check("bub_in_ready_1held", 32'(in_ready), 32'd1);
        tick;
        in_data = 8'h67;
        #1;
        check("bub_in_ready_2held", 32'(in_ready), 32'd1);
        tick;
        in_data = 8'h68;
        #1;
        check("bub_in_ready_3held", 32'(in_ready), 32'd0);
`ifdef FLOP_PIPE_OCCUPANCY_EN
        check("bub_occupancy", 32'(occupancy), 32'd3);
`endif
        tick;
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("bub_drain_0", 32'(out_data), 32'h55);
        tick;
        #1;
        check("bub_drain_1", 32'(out_data), 32'h66);
        tick;
        #1;
        check("bub_drain_2", 32'(out_data), 32'h67);
        tick;
        #1;
        check("bub_empty", 32'(out_valid), 32'd0);

        // ---- flush ----
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11;
        tick;
        in_data = 8'h22;
        tick;
        flush = 1'b1; in_data = 8'h77;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
`ifdef FLOP_PIPE_OCCUPANCY_EN
        check("flush_occupancy", 32'(occupancy), 32'd0);
`endif
        for (int c = 0; c < 5; c++) begin
            check("flush_out_valid", 32'(out_valid), 32'd0);
            check("flush_no_77", 32'(out_data != 8'h77), 32'd1);
            tick;
        end

        // ---- async reset mid-operation ----
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_data = 8'(8'hC1 + c);
            tick;
        end
        in_data = 8'hC4;
        #1;
        check("ar_full_out_valid", 32'(out_valid), 32'd1);
        check("ar_full_out_data", 32'(out_data), 32'hC1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_out_valid_now", 32'(out_valid), 32'd0);
        check("ar_out_data_now", 32'(out_data), 32'd0);
        check("ar_in_ready_now", 32'(in_ready), 32'd0);
`ifdef FLOP_PIPE_OCCUPANCY_EN
        check("ar_occupancy_now", 32'(occupancy), 32'd0);
`endif
        tick; tick;
        reset_n = 1'b1;
        in_valid = 1'b1; in_data = 8'hD0; out_ready = 1'b1;
        #1;
        check("ar_in_ready_after", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        for (int c = 1; c < 3; c++) begin
            #1;
            check("ar_out_valid_travel", 32'(out_valid), 32'd0);
            tick;
        end
        #1;
        check("ar_first_valid", 32'(out_valid), 32'd1);
        check("ar_first_data", 32'(out_data), 32'hD0);
        tick;

        // ---- DEPTH=1 simultaneous accept/consume ----
        out_ready_1 = 1'b0;
        in_valid_1 = 1'b1; in_data_1 = 8'h31;
        #1;
        check("d1_in_ready_empty", 32'(in_ready_1), 32'd1);
        tick;
        in_data_1 = 8'h32;
        #1;
        check("d1_out_valid", 32'(out_valid_1), 32'd1);
        check("d1_out_data_31", 32'(out_data_1), 32'h31);
        check("d1_in_ready_full", 32'(in_ready_1), 32'd0);
        tick;
        out_ready_1 = 1'b1;
        #1;
        check("d1_in_ready_simul", 32'(in_ready_1), 32'd1);
        check("d1_out_data_hold", 32'(out_data_1), 32'h31);
        tick;
        in_data_1 = 8'h33;
        #1;
        check("d1_out_data_32", 32'(out_data_1), 32'h32);
        check("d1_in_ready_simul2", 32'(in_ready_1), 32'd1);
`ifdef FLOP_PIPE_OCCUPANCY_EN
        check("d1_occupancy", 32'(occupancy_1), 32'd1);
`endif
        tick;
        in_valid_1 = 1'b0;
        #1;
        check("d1_out_data_33", 32'(out_data_1), 32'h33);
        tick;
        #1;
        check("d1_empty", 32'(out_valid_1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
